// File: rtl/simple_bus_master_bridge.sv
// SimpleBus master: queues 16-bit-address read/write commands and runs each as a
// multiplexed start/addr-hi, addr-lo/read, data transaction with a one-cycle response.
module simple_bus_master_bridge #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        bus_start,
  output logic        bus_read,
  output wire  [7:0]  bus_address,
  inout  wire  [7:0]  bus_data,
  inout  wire         bus_dataValid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, ADDR_LO, RD_WAIT, WR_DATA, GAP} state_t;

  state_t           state, state_nxt;
  cmd_t             fifo_mem [DEPTH];
  cmd_t             head, cmd;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [CNT_W-1:0] cnt;
  logic             dv_in;
  logic             rsp_load, rsp_write_nxt, rsp_error_nxt;
  logic [7:0]       rsp_rdata_nxt;
  logic             addr_en;
  logic [7:0]       addr_val;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign busy      = !empty || (state != IDLE);

  // Anything other than a clean 1 on dataValid counts as not-yet-valid.
  assign dv_in = (bus_dataValid === 1'b1);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
    if (pop)  cmd <= head;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state == ADDR_LO)      cnt <= '0;
      else if (state == RD_WAIT) cnt <= cnt + 1'b1;
      if (rsp_load) begin
        rsp_write <= rsp_write_nxt;
        rsp_rdata <= rsp_rdata_nxt;
        rsp_error <= rsp_error_nxt;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    rsp_load      = 1'b0;
    rsp_write_nxt = 1'b0;
    rsp_rdata_nxt = 8'h00;
    rsp_error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ADDR_LO;
        end
      end
      ADDR_LO: state_nxt = cmd.write ? WR_DATA : RD_WAIT;
      WR_DATA: begin
        state_nxt     = GAP;
        rsp_load      = 1'b1;
        rsp_write_nxt = 1'b1;
      end
      RD_WAIT: begin
        if (dv_in) begin
          state_nxt     = GAP;
          rsp_load      = 1'b1;
          rsp_rdata_nxt = bus_data;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt     = GAP;
          rsp_load      = 1'b1;
          rsp_error_nxt = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus drive follows state directly so an async reset releases it at once.
  assign bus_start = (state == IDLE) && !empty;
  assign bus_read  = (state == ADDR_LO) && !cmd.write;
  assign rsp_valid = (state == GAP);
  assign addr_en   = bus_start || (state == ADDR_LO);
  assign addr_val  = (state == ADDR_LO) ? cmd.addr[7:0] : head.addr[15:8];

  assign bus_address   = addr_en ? addr_val : 8'hzz;
  assign bus_data      = (state == WR_DATA) ? cmd.wdata : 8'hzz;
  assign bus_dataValid = (state == WR_DATA) ? 1'b1 : 1'bz;

endmodule
